seg_display_driver: RTL and testbench

//  Display side of the 8-bit counter path: takes an 8-bit binary value (e.g. a button-driven

---
 rtl/seg_pkg.sv | 37 +++
 rtl/seven_seg_decode.sv | 22 ++
 rtl/seg_display_driver.sv | 161 ++++++++++++++++
 tb/tb_seg_display_driver.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment display path: conversion FSM states,
// the BCD-to-segment pattern table and the double-dabble step helpers.
package seg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } conv_state_t;

  // Active-high segment patterns, bit order g,f,e,d,c,b,a; entry [d] is digit d.
  localparam logic [9:0][6:0] SEG_TABLE = {
    7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  localparam logic [6:0] SEG_BLANK = 7'h00;

  // Double-dabble correction: a nibble of 5 or more gets 3 added before the shift.
  function automatic logic [3:0] add3(input logic [3:0] nib);
    if (nib >= 4'd5) begin
      return nib + 4'd3;
    end else begin
      return nib;
    end
  endfunction

  // One iteration on {hund, tens, units, bin}: correct each BCD nibble, then shift left.
  function automatic logic [19:0] dd_step(input logic [19:0] sr);
    logic [19:0] t;
    t        = sr;
    t[19:16] = add3(sr[19:16]);
    t[15:12] = add3(sr[15:12]);
    t[11:8]  = add3(sr[11:8]);
    return {t[18:0], 1'b0};
  endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD digit to active-high 7-segment pattern (g..a), with blanking.
module seven_seg_decode
  import seg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] pattern
);

  // Look up the digit pattern; blanked or non-decimal codes light nothing.
  always_comb begin
    pattern = SEG_BLANK;
    if (blank) begin
      pattern = SEG_BLANK;
    end else if (bcd <= 4'd9) begin
      pattern = SEG_TABLE[bcd];
    end else begin
      pattern = SEG_BLANK;
    end
  end

endmodule

// File: rtl/seg_display_driver.sv
// 8-bit binary to 3-digit decimal display driver: sequential double-dabble
// conversion with a one-deep pending request, plus a multiplexed 4-digit scan.
module seg_display_driver
  import seg_pkg::*;
#(
  parameter int SCAN_BITS  = 16,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic       busy,
  output logic [7:0] seg,
  output logic [3:0] sel
);

  conv_state_t          state_r;
  conv_state_t          state_nxt_s;
  logic [19:0]          sr_r;
  logic [2:0]           cnt_r;
  logic                 pend_r;
  logic [7:0]           pend_val_r;
  logic [3:0]           hund_r;
  logic [3:0]           tens_r;
  logic [3:0]           units_r;
  logic [SCAN_BITS-1:0] scan_r;
  logic [1:0]           idx_s;
  logic [3:0]           digit_s;
  logic                 blank_s;
  logic [6:0]           pattern_s;
  logic [7:0]           seg_r;
  logic [3:0]           sel_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next state: a held pending value restarts conversion straight from COMMIT or IDLE.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE:   state_nxt_s = (value_valid || pend_r) ? ST_SHIFT : ST_IDLE;
      ST_SHIFT:  state_nxt_s = (cnt_r == 3'd7) ? ST_COMMIT : ST_SHIFT;
      ST_COMMIT: state_nxt_s = pend_r ? ST_SHIFT : ST_IDLE;
      default:   state_nxt_s = ST_IDLE;
    endcase
  end

  // FSM outputs: busy whenever a conversion is in flight.
  always_comb begin
    busy = 1'b0;
    if (state_r != ST_IDLE) begin
      busy = 1'b1;
    end else begin
      busy = 1'b0;
    end
  end

  // Conversion datapath, pending capture and display registers (updated only in COMMIT).
  always_ff @(posedge clk) begin
    if (rst) begin
      sr_r       <= 20'd0;
      cnt_r      <= 3'd0;
      pend_r     <= 1'b0;
      pend_val_r <= 8'd0;
      hund_r     <= 4'd0;
      tens_r     <= 4'd0;
      units_r    <= 4'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 3'd0;
          if (pend_r) begin
            // Older pending request goes first; a simultaneous strobe takes its slot.
            sr_r   <= {12'd0, pend_val_r};
            pend_r <= value_valid;
            if (value_valid) pend_val_r <= value_in;
          end else if (value_valid) begin
            sr_r <= {12'd0, value_in};
          end
        end
        ST_SHIFT: begin
          sr_r  <= dd_step(sr_r);
          cnt_r <= cnt_r + 3'd1;
          if (value_valid) begin
            pend_r     <= 1'b1;
            pend_val_r <= value_in;
          end
        end
        ST_COMMIT: begin
          hund_r  <= sr_r[19:16];
          tens_r  <= sr_r[15:12];
          units_r <= sr_r[11:8];
          cnt_r   <= 3'd0;
          if (pend_r) begin
            sr_r   <= {12'd0, pend_val_r};
            pend_r <= value_valid;
            if (value_valid) pend_val_r <= value_in;
          end else if (value_valid) begin
            pend_r     <= 1'b1;
            pend_val_r <= value_in;
          end
        end
        default: begin
          cnt_r <= 3'd0;
        end
      endcase
    end
  end

  // Free-running scan prescaler; its top two bits pick the digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_r <= '0;
    end else begin
      scan_r <= scan_r + 1'b1;
    end
  end

  assign idx_s = scan_r[SCAN_BITS-1:SCAN_BITS-2];

  // Choose the digit for the current slot and apply leading-zero blanking.
  always_comb begin
    digit_s = 4'd0;
    blank_s = 1'b1;
    case (idx_s)
      2'd0: begin digit_s = units_r; blank_s = 1'b0; end
      2'd1: begin digit_s = tens_r;  blank_s = (hund_r == 4'd0) && (tens_r == 4'd0); end
      2'd2: begin digit_s = hund_r;  blank_s = (hund_r == 4'd0); end
      2'd3: begin digit_s = 4'd0;    blank_s = 1'b1; end
      default: begin digit_s = 4'd0; blank_s = 1'b1; end
    endcase
  end

  seven_seg_decode u_decode (
    .bcd     (digit_s),
    .blank   (blank_s),
    .pattern (pattern_s)
  );

  // Output registers: dp always off, optional inversion for active-low pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r <= {8{ACTIVE_LOW}};
      sel_r <= {4{ACTIVE_LOW}};
    end else begin
      seg_r <= {8{ACTIVE_LOW}} ^ {1'b0, pattern_s};
      sel_r <= {4{ACTIVE_LOW}} ^ (4'b0001 << idx_s);
    end
  end

  assign seg = seg_r;
  assign sel = sel_r;

endmodule

// File: tb/tb_seg_display_driver.sv
// Directed bench for seg_display_driver with a 4-bit scan prescaler and active-low pins.
module tb_seg_display_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] value_in;
  logic       value_valid;
  logic       busy;
  logic [7:0] seg;
  logic [3:0] sel;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] slots [4];

  typedef struct {
    logic [7:0] value;
    logic [7:0] units;
    logic [7:0] tens;
    logic [7:0] hund;
  } vec_t;

  vec_t vecs [8];

  seg_display_driver #(.SCAN_BITS(4), .ACTIVE_LOW(1'b1)) dut (
    .clk         (clk),
    .rst         (rst),
    .value_in    (value_in),
    .value_valid (value_valid),
    .busy        (busy),
    .seg         (seg),
    .sel         (sel)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Strobe one value and return the number of cycles busy was high.
  task automatic send(input logic [7:0] v, output int cnt);
    @(negedge clk);
    value_in = v;
    value_valid = 1'b1;
    @(posedge clk);
    #1 value_valid = 1'b0;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      if (busy !== 1'b1) break;
      cnt++;
      @(posedge clk);
      #1;
    end
  endtask

  // Watch one full scan period and record seg per selected digit.
  task automatic scan();
    for (int i = 0; i < 4; i++) slots[i] = 8'h00;
    @(posedge clk);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      case (sel)
        4'b1110: slots[0] = seg;
        4'b1101: slots[1] = seg;
        4'b1011: slots[2] = seg;
        4'b0111: slots[3] = seg;
        default: ;
      endcase
    end
  endtask

  task automatic check_disp(input string name, input logic [7:0] u, input logic [7:0] t,
                            input logic [7:0] h);
    scan();
    check({name, "_units"}, {24'd0, slots[0]}, {24'd0, u});
    check({name, "_tens"},  {24'd0, slots[1]}, {24'd0, t});
    check({name, "_hund"},  {24'd0, slots[2]}, {24'd0, h});
    check({name, "_dig3"},  {24'd0, slots[3]}, 32'h0000_00FF);
  endtask

  initial begin
    int cnt;
    logic [3:0] exp_sel;
    logic saw_x;

    vecs[0] = '{8'd255, 8'h92, 8'h92, 8'hA4};
    vecs[1] = '{8'd7,   8'hF8, 8'hFF, 8'hFF};
    vecs[2] = '{8'd0,   8'hC0, 8'hFF, 8'hFF};
    vecs[3] = '{8'd100, 8'hC0, 8'hC0, 8'hF9};
    vecs[4] = '{8'd42,  8'hA4, 8'h99, 8'hFF};
    vecs[5] = '{8'd10,  8'hC0, 8'hF9, 8'hFF};
    vecs[6] = '{8'd199, 8'h90, 8'h90, 8'hF9};
    vecs[7] = '{8'd58,  8'h80, 8'h92, 8'hFF};

    // 1: reset state and scan rotation with zero displayed.
    rst = 1'b1;
    value_in = 8'd0;
    value_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_seg",  {24'd0, seg}, 32'h0000_00FF);
    check("rst_sel",  {28'd0, sel}, 32'h0000_000F);
    check("rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    for (int n = 1; n <= 16; n++) begin
      @(negedge clk);
      exp_sel = ~(4'b0001 << ((n - 1) / 4));
      check("scan_sel", {28'd0, sel}, {28'd0, exp_sel});
      check("scan_seg", {24'd0, seg}, ((n - 1) / 4 == 0) ? 32'h0000_00C0 : 32'h0000_00FF);
    end

    // 2/3: isolated conversions from the vector table.
    for (int v = 0; v < 8; v++) begin
      send(vecs[v].value, cnt);
      check($sformatf("busy_len_%0d", vecs[v].value), cnt, 32'd9);
      check_disp($sformatf("val_%0d", vecs[v].value), vecs[v].units, vecs[v].tens, vecs[v].hund);
    end

    // 4: 100 then 42 three cycles later, chained through pending.
    @(negedge clk);
    value_in = 8'd100;
    value_valid = 1'b1;
    @(posedge clk);
    cnt = 0;
    for (int j = 0; j < 60; j++) begin
      @(negedge clk);
      if (j == 2) begin
        value_in = 8'd42;
        value_valid = 1'b1;
      end else begin
        value_valid = 1'b0;
      end
      if (busy !== 1'b1) break;
      cnt++;
    end
    check("chain_busy_len", cnt, 32'd18);
    check_disp("chain_42", 8'hA4, 8'h99, 8'hFF);

    // 5: reset mid-conversion with a pending value drops both.
    @(negedge clk);
    value_in = 8'd200;
    value_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    value_valid = 1'b0;
    @(negedge clk);
    value_in = 8'd77;
    value_valid = 1'b1;
    @(negedge clk);
    value_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    cnt = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      if (busy === 1'b1) cnt++;
    end
    check("rst_no_restart", cnt, 32'd0);
    check_disp("rst_mid", 8'hC0, 8'hFF, 8'hFF);

    // 6: strobe every cycle with 0..19; display settles on the last value.
    for (int v = 0; v < 20; v++) begin
      @(negedge clk);
      value_in = 8'(v);
      value_valid = 1'b1;
    end
    @(negedge clk);
    value_valid = 1'b0;
    saw_x = 1'b0;
    cnt = 0;
    while (busy === 1'b1 && cnt < 200) begin
      @(negedge clk);
      if ($isunknown(seg) || $isunknown(sel)) saw_x = 1'b1;
      cnt++;
    end
    check("burst_idle", {31'd0, busy}, 32'd0);
    check("burst_no_x", {31'd0, saw_x}, 32'd0);
    check_disp("burst_19", 8'h90, 8'hF9, 8'hFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
